// File: rtl/muldiv_pkg.sv
// Package for the HI/LO multiply/divide engine.
// Holds the op encodings and the engine FSM state type shared by the
// engine, its bus interface and the testbench.
// Optional build macro: UNSIGNED_OPS_EN (enables op[1] = unsigned ops).
package muldiv_pkg;

    // op[0] selects divide, op[1] selects the unsigned variant.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/hilo_muldiv_engine_if.sv
// Request/result bundle between the control FSM (master) and the
// multiply/divide engine (slave).
// Signals: start, op, a, b (master -> engine); hi, lo, busy, done,
// div_by_zero, dbg_state (engine -> master).
//
// Handshake: start is a one-cycle request sampled only while the engine is
// idle (busy==0 and done==0); a start at any other time is dropped, never
// queued. a/b/op are captured on the accepting edge and may change
// afterwards. done is a one-cycle pulse; hi/lo are valid from that cycle
// and hold until the next completing operation. div_by_zero is only ever
// high together with done.
interface hilo_muldiv_engine_if #(parameter int WIDTH = 32);
    import muldiv_pkg::*;

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    state_t           dbg_state;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_by_zero, dbg_state
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_by_zero, dbg_state
    );

endinterface

// File: rtl/restoring_div_step.sv
// One iteration of restoring division on unsigned magnitudes.
// The {rem, quo} pair is shifted left by one; the divisor is trial-
// subtracted from the upper half and the new quotient bit enters at the
// bottom of quo.
// Ports: rem_in/quo_in (current partial remainder / dividend-quotient
// shift register), divisor, rem_out/quo_out (values after this step).
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    // rem_in < divisor always holds, so diff fits in WIDTH+1 bits and its
    // top bit is a clean borrow.
    always_comb begin
        if (diff[WIDTH]) begin
            rem_out = shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/hilo_muldiv_engine.sv
// Multicycle multiply/divide engine feeding the HI/LO registers.
// MULT: radix-2 Booth, one step per cycle, WIDTH steps.
// DIV: restoring division on magnitudes, WIDTH steps, then sign fix-up
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Divide by zero skips straight to FINISH and leaves hi/lo untouched.
// Ports: clock, reset (synchronous, active-low), bus (slave side of
// hilo_muldiv_engine_if).
// Build macro: UNSIGNED_OPS_EN -- when defined, op[1] selects multu/divu;
// otherwise op[1] is ignored and every operation is signed.
module hilo_muldiv_engine
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    hilo_muldiv_engine_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             dz_r;

    // Booth accumulator: hi part is two bits wider than the operands so a
    // zero-extended unsigned multiplicand and the -2^(W-1) corner case
    // never overflow during add/subtract.
    logic [WIDTH+1:0] mcand;
    logic [WIDTH+1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             acc_q;
    logic             mult_fix;

    logic [WIDTH-1:0] rem_r, quo_r, dvsr;
    logic             neg_q, neg_r;

    logic             uns;

`ifdef UNSIGNED_OPS_EN
    assign uns = bus.op[1];
`else
    logic unused_op1;
    assign uns        = 1'b0;
    assign unused_op1 = bus.op[1];
`endif

    // Operand magnitudes for the divider (signed ops only).
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = (!uns && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag = (!uns && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // ---------------- Booth step ----------------
    logic [WIDTH+1:0] booth_sum, booth_hi_nxt;
    logic [WIDTH-1:0] booth_lo_nxt, prod_hi;

    always_comb begin
        booth_sum = acc_hi;
        case ({acc_lo[0], acc_q})
            2'b01:   booth_sum = acc_hi + mcand;
            2'b10:   booth_sum = acc_hi - mcand;
            default: booth_sum = acc_hi;
        endcase
    end

    assign booth_hi_nxt = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
    assign booth_lo_nxt = {booth_sum[0], acc_lo[WIDTH-1:1]};
    // Signed Booth treats the multiplier MSB as -2^(W-1); for an unsigned
    // multiplier with MSB set, one more multiplicand at weight 2^W fixes it.
    assign prod_hi = booth_hi_nxt[WIDTH-1:0] + (mult_fix ? mcand[WIDTH-1:0] : '0);

    // ---------------- Divide step ----------------
    logic [WIDTH-1:0] rem_nxt, quo_nxt;

    restoring_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .divisor (dvsr),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    // ---------------- FSM ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.op[0])          state_nxt = MULT;
                    else if (bus.b == '0)    state_nxt = FINISH;
                    else                     state_nxt = DIV;
                end
            end
            MULT, DIV: if (cnt == LAST_STEP) state_nxt = FINISH;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // hi/lo are loaded on the edge that enters FINISH, so they are already
    // valid in the done cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            dz_r     <= 1'b0;
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            acc_q    <= 1'b0;
            mult_fix <= 1'b0;
            rem_r    <= '0;
            quo_r    <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt      <= '0;
                        dz_r     <= bus.op[0] && (bus.b == '0);
                        mcand    <= uns ? {2'b00, bus.a} : {{2{bus.a[WIDTH-1]}}, bus.a};
                        acc_hi   <= '0;
                        acc_lo   <= bus.b;
                        acc_q    <= 1'b0;
                        mult_fix <= uns && bus.b[WIDTH-1];
                        rem_r    <= '0;
                        quo_r    <= a_mag;
                        dvsr     <= b_mag;
                        neg_q    <= !uns && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r    <= !uns && bus.a[WIDTH-1];
                    end
                end
                MULT: begin
                    cnt    <= cnt + CNT_W'(1);
                    acc_hi <= booth_hi_nxt;
                    acc_lo <= booth_lo_nxt;
                    acc_q  <= acc_lo[0];
                    if (cnt == LAST_STEP) begin
                        hi_r <= prod_hi;
                        lo_r <= booth_lo_nxt;
                    end
                end
                DIV: begin
                    cnt   <= cnt + CNT_W'(1);
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    if (cnt == LAST_STEP) begin
                        hi_r <= neg_r ? -rem_nxt : rem_nxt;
                        lo_r <= neg_q ? -quo_nxt : quo_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == FINISH);
    assign bus.div_by_zero = (state == FINISH) && dz_r;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_hilo_muldiv_engine.sv
// Testbench for hilo_muldiv_engine: directed corner cases plus randomized
// operations, checked against a plain-arithmetic reference model.
module tb_hilo_muldiv_engine;
    import muldiv_pkg::*;

    logic clock;
    logic reset;

    hilo_muldiv_engine_if #(.WIDTH(32)) bus ();

    hilo_muldiv_engine #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int          total;
    int          bad;
    logic [64:0] exp_q[$];      // {div_by_zero, hi, lo}
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference model: result from integer arithmetic on the operands.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic   u;
        longint sx, sy, p, q, r;
        u = 1'b0;
`ifdef UNSIGNED_OPS_EN
        u = o[1];
`endif
        if (u) begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        if (!o[0]) begin
            p = sx * sy;
            return {1'b0, p[63:32], p[31:0]};
        end
        if (y == 32'd0) return {1'b1, mdl_hi, mdl_lo};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset  = 1'b1;
        mdl_hi = '0;
        mdl_lo = '0;
        exp_q.delete();
    endtask

    // Issue one operation and walk it cycle by cycle. Called at a negedge.
    // pulse_at > 0 re-asserts start in that busy cycle (must be ignored).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int pulse_at);
        logic [64:0] e;
        logic [64:0] got;
        int          lat;
        e = model(o, x, y);
        exp_q.push_back(e);
        lat = e[64] ? 1 : 33;
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clock);
        bus.a = $urandom;
        bus.b = $urandom;
        for (int k = 1; k <= lat; k++) begin
            bus.start = 1'b0;
            check($sformatf("busy_done_dz c%0d", k),
                  {61'b0, bus.busy, bus.done, bus.div_by_zero},
                  {61'b0, 1'b1, k == lat, (k == lat) && e[64]});
            if (k == lat) begin
                got = exp_q.pop_front();
                check("hi", bus.hi, got[63:32]);
                check("lo", bus.lo, got[31:0]);
                mdl_hi = got[63:32];
                mdl_lo = got[31:0];
            end
            if (k == pulse_at) begin
                bus.start = 1'b1;
                bus.op    = OP_MULT;
                bus.a     = 32'd9;
            end
            @(negedge clock);
        end
        bus.start = 1'b0;
        check("idle_after", {62'b0, bus.busy, bus.done}, 64'd0);
        check("hold", {bus.hi, bus.lo}, {mdl_hi, mdl_lo});
    endtask

    // Start a divide and pull reset in cycle 15; no done may follow.
    task automatic run_abort();
        bit seen;
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        for (int k = 1; k < 15; k++) @(negedge clock);
        check("abort_busy_c15", bus.busy, 1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        mdl_hi = '0;
        mdl_lo = '0;
        exp_q.delete();
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] edge_vals[5];

    initial begin
        total     = 0;
        bad       = 0;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        apply_reset();
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dz", bus.div_by_zero, 0);
        check("rst_state", bus.dbg_state, IDLE);

        run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(OP_DIV, 32'h0000_0451, 32'h20, 0);     // leaves hi=0x11, lo=0x22
        run_op(OP_DIV, 32'd5, 32'd0, 0);
        run_op(OP_MULT, 32'd3, 32'd4, 10);
        run_abort();
        run_op(OP_MULT, 32'd5, 32'd6, 0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(OP_MULTU, 32'h8000_0001, 32'hFFFF_FFFF, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y;
            x = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            run_op(2'($urandom_range(0, 3)), x, y, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_engine.md
Name: hilo_muldiv_engine

Overview:
Multicycle signed multiply/divide engine feeding the HI and LO architectural registers of the multicycle MIPS core.
- Operands come from the A/B register outputs; start is issued by the control FSM.
- Results are presented on hi/lo with a one-cycle done pulse, which the control FSM uses to assert HIWrite/LOWrite.
- Divide-by-zero is flagged for the exception path.

Parameters:
WIDTH, 32, operand/result width; must be even and >= 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  2  bit0: 0=mult, 1=div; bit1: unsigned (used only with UNSIGNED_OPS_EN)
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
hi  output  WIDTH  mult: upper product; div: remainder
lo  output  WIDTH  mult: lower product; div: quotient
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  one-cycle pulse, hi/lo valid and stable from this cycle
div_by_zero  output  1  one-cycle pulse coincident with done when div with b==0

Behaviour:
- One clock; reset is synchronous and active-low (reset==0 at a rising clock edge resets).
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
- States: IDLE, MULT, DIV, FINISH.
  - IDLE: start=1 latches a, b, op. op[0]=0 -> MULT; op[0]=1 with b!=0 -> DIV; op[0]=1 with b==0 -> FINISH with dz flag set.
  - MULT: radix-2 Booth, one step per cycle, WIDTH steps. Holds a 2*WIDTH+1 accumulator {hi_acc, lo_acc, q_-1}; arithmetic right shift each step.
  - DIV: restoring division on operand magnitudes, one quotient bit per cycle, WIDTH steps. Then sign fix-up: quotient negated if signs differ; remainder takes the dividend's sign (truncation toward zero, MIPS semantics).
  - FINISH: one cycle. Updates hi/lo (except div-by-zero), done=1, then -> IDLE.
- Latency: start accepted at edge N -> done high in cycle N+WIDTH+1 (33 for WIDTH=32). Div-by-zero: done in cycle N+1.
- Div-by-zero: hi/lo keep previous values; div_by_zero=1 with done.
- Overflow case: 0x80000000 / -1 -> lo=0x80000000, hi=0. Wraps, no flag.
- Mult result is the full 64-bit signed product. No overflow condition exists.
- start while busy or in FINISH is ignored; no queuing.
- a and b may change after acceptance without effect on the result.
- hi/lo change only in the FINISH cycle; they hold between operations.
- Reset mid-operation aborts immediately. All outputs go to reset values and no done is issued.

Optional Feature:
UNSIGNED_OPS_EN
- Defined: op[1]=1 selects multu/divu. Operands are treated as unsigned: zero-extended Booth, divide without sign fix-up.
- Not defined: op[1] is ignored and all operations are signed. Latency is identical in both builds.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULT=2'b00, OP_DIV=2'b01, OP_MULTU=2'b10, OP_DIVU=2'b11
  - state enum: IDLE, MULT, DIV, FINISH
- Sub-module restoring_div_step: combinational single iteration {rem, quo} -> {rem', quo'}, instantiated once in the DIV datapath.
- Booth step, FSM and counter stay in the top.

Test Plan:
- mult a=7, b=-3 (0xFFFFFFFD) -> done at cycle 33 after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1-33.
- div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- div a=5, b=0 with prior hi=0x11, lo=0x22 -> done and div_by_zero pulse at cycle 1; hi=0x11, lo=0x22 unchanged.
- mult 3*4, start re-pulsed at cycle 10 with a=9 -> second start ignored; single done at cycle 33 with lo=12, hi=0.
- reset=0 at cycle 15 of a div -> next cycle busy=0, hi=lo=0, no done; a fresh start completes normally.
- UNSIGNED_OPS_EN: op=2'b10, a=0xFFFFFFFF, b=2 -> hi=1, lo=0xFFFFFFFE. Without macro, same stimulus -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
